// File: rtl/m_mem_ctrl_if.sv
// Data-memory bus between the M-stage access controller and memory (or a wait-state bridge).
// Single outstanding request; the controller holds all request fields stable until bus_ack.
interface m_mem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/m_mem_ctrl.sv
// M-stage load/store controller: alignment check, req/ack bus access with timeout,
// pipeline stall while busy, lane-replicated store data and sign/zero-extended load data.
module m_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        M_Req,
  input  logic        M_Write,
  input  logic [1:0]  M_Size,
  input  logic        M_Unsigned,
  input  logic [31:0] M_Addr,
  input  logic [31:0] M_WData,
  output logic        M_Stall,
  output logic        M_Done,
  output logic [1:0]  M_Exc,
  output logic [31:0] M_RData,
  m_mem_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_TMO  = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane_p1;
  logic [1:0]  size_p1;
  logic        uns_p1;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lo;
      SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] src);
    case (size)
      SZ_BYTE: store_data = {4{src[7:0]}};
      SZ_HALF: store_data = {2{src[15:0]}};
      default: store_data = src;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] lo,
                                           input logic [1:0] size, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(raw >> {lo, 3'b000});
    h = 16'(raw >> {lo[1], 4'b0000});
    case (size)
      SZ_BYTE: load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = raw;
    endcase
  endfunction

  // Stall covers the launch cycle and every REQ cycle; DONE lets the instruction retire.
  assign M_Stall = ((state == IDLE) && M_Req) || (state == REQ);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      lane_p1       <= 2'd0;
      size_p1       <= 2'd0;
      uns_p1        <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_be    <= 4'd0;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
      M_Done        <= 1'b0;
      M_Exc         <= 2'd0;
      M_RData       <= 32'd0;
    end else begin
      M_Done <= 1'b0;
      M_Exc  <= 2'd0;
      case (state)
        // IDLE -> launch or reject
        IDLE: begin
          if (M_Req) begin
            if (misaligned(M_Size, M_Addr[1:0])) begin
              state  <= DONE;
              M_Done <= 1'b1;
              M_Exc  <= M_Write ? EXC_ADES : EXC_ADEL;
            end else begin
              state         <= REQ;
              wait_cnt      <= 8'd0;
              lane_p1       <= M_Addr[1:0];
              size_p1       <= M_Size;
              uns_p1        <= M_Unsigned;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= M_Write;
              bus.bus_be    <= byte_en(M_Size, M_Addr[1:0]);
              bus.bus_addr  <= {M_Addr[31:2], 2'b00};
              bus.bus_wdata <= store_data(M_Size, M_WData);
            end
          end
        end
        // REQ -> wait for ack; ack beats the timeout when both land together
        REQ: begin
          if (bus.bus_ack) begin
            state       <= DONE;
            bus.bus_req <= 1'b0;
            M_Done      <= 1'b1;
            if (!bus.bus_we)
              M_RData <= load_ext(bus.bus_rdata, lane_p1, size_p1, uns_p1);
          end else if (wait_cnt == TMO_LAST) begin
            state       <= DONE;
            bus.bus_req <= 1'b0;
            M_Done      <= 1'b1;
            M_Exc       <= EXC_TMO;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        // DONE -> retire
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl: each access pushes its expected completion onto a
// scoreboard that is popped and compared when M_Done pulses.
module tb_m_mem_ctrl;
  localparam int TMO = 15;

  logic        clk;
  logic        rstn;
  logic        M_Req, M_Write, M_Unsigned;
  logic [1:0]  M_Size;
  logic [31:0] M_Addr, M_WData;
  logic        M_Stall, M_Done;
  logic [1:0]  M_Exc;
  logic [31:0] M_RData;

  m_mem_ctrl_if bif ();

  m_mem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .M_Req     (M_Req),
    .M_Write   (M_Write),
    .M_Size    (M_Size),
    .M_Unsigned(M_Unsigned),
    .M_Addr    (M_Addr),
    .M_WData   (M_WData),
    .M_Stall   (M_Stall),
    .M_Done    (M_Done),
    .M_Exc     (M_Exc),
    .M_RData   (M_RData),
    .bus       (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  exc;
    int          done_cyc;
    int          req_cyc;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  logic [31:0] last_rdata = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // wait_n: wait cycles before ack (ack in REQ cycle wait_n+1); negative = never ack
  task automatic access(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int wait_n,
                        input logic [31:0] rdata_in, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_exc);
    exp_t e;
    exp_t got;
    int   cyc;
    int   reqc;
    bit   done;
    e.exc = exp_exc;
    e.rdata = (!wr && exp_exc == 2'd0) ? exp_rdata : last_rdata;
    if (exp_exc == 2'd1 || exp_exc == 2'd2) begin
      e.done_cyc = 1; e.req_cyc = 0;
    end else if (wait_n < 0) begin
      e.done_cyc = TMO + 1; e.req_cyc = TMO;
    end else begin
      e.done_cyc = wait_n + 2; e.req_cyc = wait_n + 1;
    end
    last_rdata = e.rdata;

    @(negedge clk);
    M_Req = 1'b1; M_Write = wr; M_Size = sz; M_Unsigned = uns; M_Addr = addr; M_WData = wdata;
    bif.bus_ack = 1'b0; bif.bus_rdata = rdata_in;
    sb.push_back(e);
    #1;
    check($sformatf("%s_stall_c0", tag), 32'(M_Stall), 32'd1);
    cyc = 0; reqc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (M_Done === 1'b1) begin
        done = 1'b1;
        got = sb.pop_front();
        check($sformatf("%s_done_cyc", tag), 32'(cyc), 32'(got.done_cyc));
        check($sformatf("%s_req_cyc", tag), 32'(reqc), 32'(got.req_cyc));
        check($sformatf("%s_rdata", tag), M_RData, got.rdata);
        check($sformatf("%s_exc", tag), 32'(M_Exc), 32'(got.exc));
        check($sformatf("%s_stall_done", tag), 32'(M_Stall), 32'd0);
        check($sformatf("%s_req_done", tag), 32'(bif.bus_req), 32'd0);
      end else begin
        if (M_Exc !== 2'd0) check($sformatf("%s_exc_idle", tag), 32'(M_Exc), 32'd0);
        if (bif.bus_req === 1'b1) begin
          reqc++;
          if (reqc == 1) begin
            check($sformatf("%s_addr", tag), bif.bus_addr, {addr[31:2], 2'b00});
            check($sformatf("%s_be", tag), 32'(bif.bus_be), 32'(exp_be));
            check($sformatf("%s_we", tag), 32'(bif.bus_we), 32'(wr));
            check($sformatf("%s_wdata", tag), bif.bus_wdata, exp_wdata);
          end
          check($sformatf("%s_stall_req", tag), 32'(M_Stall), 32'd1);
          bif.bus_ack = (wait_n >= 0 && reqc > wait_n) ? 1'b1 : 1'b0;
        end
      end
    end
    if (!done) begin
      check($sformatf("%s_no_done", tag), 32'(cyc), 32'(e.done_cyc));
      void'(sb.pop_front());
    end
    M_Req = 1'b0; bif.bus_ack = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s_done_pulse", tag), 32'(M_Done), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    M_Req = 1'b0; M_Write = 1'b0; M_Size = 2'd0; M_Unsigned = 1'b0;
    M_Addr = 32'd0; M_WData = 32'd0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bif.bus_req), 32'd0);
    check("rst_we", 32'(bif.bus_we), 32'd0);
    check("rst_be", 32'(bif.bus_be), 32'd0);
    check("rst_addr", bif.bus_addr, 32'd0);
    check("rst_wdata", bif.bus_wdata, 32'd0);
    check("rst_done", 32'(M_Done), 32'd0);
    check("rst_exc", 32'(M_Exc), 32'd0);
    check("rst_rdata", M_RData, 32'd0);
    check("rst_stall0", 32'(M_Stall), 32'd0);
    M_Req = 1'b1; #1;
    check("rst_stall1", 32'(M_Stall), 32'd1);
    M_Req = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // loads and extension
    access("lw",    1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 32'h8899AABB, 4'b1111, 32'h0, 32'h8899AABB, 2'd0);
    access("lb",    1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 1, 32'h80112233, 4'b1000, 32'h0, 32'hFFFFFF80, 2'd0);
    access("lbu",   1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 0, 32'h80112233, 4'b1000, 32'h0, 32'h00000080, 2'd0);
    access("lhu",   1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 0, 32'h80112233, 4'b1100, 32'h0, 32'h00008011, 2'd0);
    access("lh_lo", 1'b0, 2'd1, 1'b0, 32'h1000, 32'h0, 0, 32'h80112233, 4'b0011, 32'h0, 32'h00002233, 2'd0);
    access("lh_hi", 1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 2, 32'h80112233, 4'b1100, 32'h0, 32'hFFFF8011, 2'd0);
    access("lbu1",  1'b0, 2'd0, 1'b1, 32'h1001, 32'h0, 0, 32'h80112233, 4'b0010, 32'h0, 32'h00000022, 2'd0);
    // stores leave M_RData alone even with junk on bus_rdata
    access("sb",    1'b1, 2'd0, 1'b0, 32'h2001, 32'h123456AB, 0, 32'hDEADBEEF, 4'b0010, 32'hABABABAB, 32'h0, 2'd0);
    access("sh",    1'b1, 2'd1, 1'b0, 32'h2002, 32'h123456AB, 0, 32'hDEADBEEF, 4'b1100, 32'h56AB56AB, 32'h0, 2'd0);
    access("sw",    1'b1, 2'd2, 1'b0, 32'h2004, 32'hCAFEF00D, 2, 32'hDEADBEEF, 4'b1111, 32'hCAFEF00D, 32'h0, 2'd0);
    // address exceptions
    access("lw_mis", 1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0, 32'h0, 2'd1);
    access("sh_mis", 1'b1, 2'd1, 1'b0, 32'h3001, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0, 32'h0, 2'd2);
    access("sz3",    1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 0, 32'h11111111, 4'b0000, 32'h0, 32'h0, 2'd1);
    // timeout, then ack exactly on the last allowed REQ cycle
    access("tmo",    1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, -1, 32'h22222222, 4'b1111, 32'h0, 32'h0, 2'd3);
    access("ack15",  1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, TMO - 1, 32'h13579BDF, 4'b1111, 32'h0, 32'h13579BDF, 2'd0);

    // reset in the middle of REQ after 3 wait cycles
    @(negedge clk);
    M_Req = 1'b1; M_Write = 1'b0; M_Size = 2'd2; M_Unsigned = 1'b0; M_Addr = 32'h5000;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h33333333;
    repeat (4) @(posedge clk);
    #1;
    check("mid_req_before", 32'(bif.bus_req), 32'd1);
    rstn = 1'b0; #1;
    check("mid_req_drop", 32'(bif.bus_req), 32'd0);
    check("mid_done", 32'(M_Done), 32'd0);
    check("mid_stall", 32'(M_Stall), 32'd1);
    M_Req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("mid_no_done", 32'(M_Done), 32'd0);
    end
    check("mid_rdata_rst", M_RData, 32'd0);
    @(negedge clk); rstn = 1'b1;
    last_rdata = 32'd0;
    access("lw_post", 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 32'h0F0F0F0F, 4'b1111, 32'h0, 32'h0F0F0F0F, 2'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
